harq_combine_scheduler: RTL and testbench



---
 rtl/harq_comb_pkg.sv | 27 ++
 rtl/harq_buf_credit.sv | 46 ++++
 rtl/harq_combine_scheduler.sv | 230 +++++++++++++++++++++++
 tb/tb_harq_combine_scheduler.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harq_comb_pkg.sv
// Shared constants for the HARQ soft-combine scheduler.
//   USER_IDX_W : width of the user index presented to the combine datapath
//   BUF_DEPTH  : number of ping/pong output buffers tracked by the credit counter
//   ST_*       : one-hot scheduler state encodings, *_B the matching bit positions
package harq_comb_pkg;

  localparam int USER_IDX_W = 4;
  localparam int BUF_DEPTH  = 2;

  localparam int ST_W   = 6;
  localparam int IDLE_B = 0;
  localparam int SCAN_B = 1;
  localparam int ARM_B  = 2;
  localparam int REQ_B  = 3;
  localparam int WAIT_B = 4;
  localparam int DONE_B = 5;

  typedef logic [ST_W-1:0] state_t;

  localparam state_t ST_IDLE = 6'b000001;
  localparam state_t ST_SCAN = 6'b000010;
  localparam state_t ST_ARM  = 6'b000100;
  localparam state_t ST_REQ  = 6'b001000;
  localparam state_t ST_WAIT = 6'b010000;
  localparam state_t ST_DONE = 6'b100000;

endpackage

// File: rtl/harq_buf_credit.sv
// Saturating occupancy counter for the ping/pong output buffers.
// A buffer becomes occupied when a combine finishes and is released when the
// HARQ send of that buffer finishes. Simultaneous fill and release cancel.
//   clk_i   : core clock
//   rst_i   : synchronous active-high reset
//   inc_i   : one buffer filled
//   dec_i   : one buffer sent
//   occ_o   : filled-but-unsent buffers, 0..DEPTH
//   full_o  : occ_o == DEPTH
module harq_buf_credit
  import harq_comb_pkg::*;
#(
  parameter int DEPTH = BUF_DEPTH,
  parameter int OCC_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [OCC_W-1:0] occ_o,
  output logic             full_o
);

  logic [OCC_W-1:0] occ_q, occ_d;

  always_comb begin
    occ_d = occ_q;
    if (inc_i && !dec_i && (occ_q != OCC_W'(DEPTH))) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (dec_i && !inc_i && (occ_q != '0)) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ_o  = occ_q;
  assign full_o = (occ_q == OCC_W'(DEPTH));

endmodule

// File: rtl/harq_combine_scheduler.sv
// Per-slot sequencer for the HARQ soft-combine datapath.
// On a slot start it walks every enabled user with a nonzero code-block count
// and issues one combine request per code block, waiting for each completion.
// A request is never launched while both output buffers hold unsent data.
//
// Optional build macro HARQ_COMB_SCHED_WATCHDOG_EN adds a per-code-block
// completion watchdog and the sticky o_timeout_err output.
//
// Ports:
//   i_core_clk / i_rx_rst        clock, synchronous active-high reset
//   i_rdm_slot_start             slot-start pulse
//   i_user_enable, i_user_cb_num per-user enable mask and code-block counts
//   o_Combine_process_request    one-cycle combine start pulse
//   o_Combine_user_index         user of the current request
//   o_cb_index                   code block of the current request
//   i_current_cb_combine_comp    combine-done pulse
//   i_SENDHARQ_Data_Comp         one buffer sent
//   o_busy / o_slot_done         slot in progress / slot finished pulse
//   o_slot_overrun               slot start seen while busy
//   o_buf_occupancy              filled-but-unsent buffers (0..2)
//   o_timeout_err                sticky watchdog flag (watchdog build only)
//
// state | meaning
// IDLE  | waiting for slot start
// SCAN  | evaluating user user_q for pending code blocks
// ARM   | holding until an output buffer is free
// REQ   | combine request pulse
// WAIT  | waiting for combine completion of cb_q
// DONE  | slot finished, o_slot_done pulse
module harq_combine_scheduler
  import harq_comb_pkg::*;
#(
  parameter int NUM_USERS      = 8,
  parameter int CB_W           = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rst,
  input  logic                      i_rdm_slot_start,
  input  logic [NUM_USERS-1:0]      i_user_enable,
  input  logic [NUM_USERS*CB_W-1:0] i_user_cb_num,
  output logic                      o_Combine_process_request,
  output logic [USER_IDX_W-1:0]     o_Combine_user_index,
  output logic [CB_W-1:0]           o_cb_index,
  input  logic                      i_current_cb_combine_comp,
  input  logic                      i_SENDHARQ_Data_Comp,
  output logic                      o_busy,
  output logic                      o_slot_done,
  output logic                      o_slot_overrun,
  output logic [1:0]                o_buf_occupancy
`ifdef HARQ_COMB_SCHED_WATCHDOG_EN
  ,output logic                     o_timeout_err
`endif
);

  state_t                    state_q, state_d;
  logic [NUM_USERS-1:0]      en_q, en_d;
  logic [NUM_USERS*CB_W-1:0] cnt_q, cnt_d;
  logic [USER_IDX_W-1:0]     user_q, user_d;
  logic [CB_W-1:0]           cb_q, cb_d;
  logic                      overrun_q;

  logic [NUM_USERS-1:0] elig;
  logic                 cur_elig;
  logic                 any_left;
  logic [CB_W-1:0]      cur_cnt;
  logic [CB_W:0]        cb_inc;
  logic                 last_cb;
  logic                 comp;
  logic                 buf_full;
  logic [1:0]           occ;
  logic                 wd_expired;

  assign comp = i_current_cb_combine_comp;

  harq_buf_credit #(
    .DEPTH (BUF_DEPTH),
    .OCC_W (2)
  ) u_buf_credit (
    .clk_i  (i_core_clk),
    .rst_i  (i_rx_rst),
    .inc_i  (i_current_cb_combine_comp),
    .dec_i  (i_SENDHARQ_Data_Comp),
    .occ_o  (occ),
    .full_o (buf_full)
  );

  // A user only costs a SCAN cycle if some eligible user remains at or above
  // it; once none remain the slot ends immediately.
  always_comb begin
    elig     = '0;
    cur_elig = 1'b0;
    any_left = 1'b0;
    cur_cnt  = '0;
    for (int u = 0; u < NUM_USERS; u++) begin
      elig[u] = en_q[u] && (cnt_q[u*CB_W +: CB_W] != '0);
      if (USER_IDX_W'(u) == user_q) begin
        cur_elig = elig[u];
        cur_cnt  = cnt_q[u*CB_W +: CB_W];
      end
      if ((USER_IDX_W'(u) >= user_q) && elig[u]) begin
        any_left = 1'b1;
      end
    end
  end

  // One extra bit so a count of 2^CB_W-1 compares without wrapping.
  assign cb_inc  = {1'b0, cb_q} + {{CB_W{1'b0}}, 1'b1};
  assign last_cb = (cb_inc == {1'b0, cur_cnt});

`ifdef HARQ_COMB_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            timeout_q;

  // wd_q counts completed WAIT cycles, so expiry lands on WAIT cycle TIMEOUT_CYCLES.
  assign wd_expired = state_q[WAIT_B] && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q[REQ_B]) begin
        wd_q <= '0;
      end else if (state_q[WAIT_B]) begin
        wd_q <= wd_q + WD_W'(1);
      end
      if (wd_expired && !comp) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign o_timeout_err = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
  assign wd_expired         = 1'b0;
`endif

  // State register
  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_rdm_slot_start) state_d = ST_SCAN;
      ST_SCAN: begin
        if (cur_elig) begin
          state_d = ST_ARM;
        end else if (!any_left) begin
          state_d = ST_DONE;
        end
      end
      ST_ARM:  if (!buf_full) state_d = ST_REQ;
      ST_REQ:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (comp) begin
          state_d = last_cb ? ST_SCAN : ST_ARM;
        end else if (wd_expired) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    o_busy                    = !state_q[IDLE_B];
    o_Combine_process_request = state_q[REQ_B];
    o_slot_done               = state_q[DONE_B];
  end

  // Slot context and walk position
  always_comb begin
    en_d   = en_q;
    cnt_d  = cnt_q;
    user_d = user_q;
    cb_d   = cb_q;
    if (state_q[IDLE_B] && i_rdm_slot_start) begin
      en_d   = i_user_enable;
      cnt_d  = i_user_cb_num;
      user_d = '0;
      cb_d   = '0;
    end else if (state_q[SCAN_B] && !cur_elig && any_left) begin
      user_d = user_q + USER_IDX_W'(1);
    end else if (state_q[WAIT_B] && comp) begin
      if (last_cb) begin
        cb_d   = '0;
        user_d = user_q + USER_IDX_W'(1);
      end else begin
        cb_d = cb_inc[CB_W-1:0];
      end
    end
  end

  always_ff @(posedge i_core_clk) begin
    if (i_rx_rst) begin
      en_q      <= '0;
      cnt_q     <= '0;
      user_q    <= '0;
      cb_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      user_q    <= user_d;
      cb_q      <= cb_d;
      // Includes DONE: a start landing on the final cycle is not accepted.
      overrun_q <= i_rdm_slot_start && !state_q[IDLE_B];
    end
  end

  assign o_Combine_user_index = user_q;
  assign o_cb_index           = cb_q;
  assign o_slot_overrun       = overrun_q;
  assign o_buf_occupancy      = occ;

endmodule

// File: tb/tb_harq_combine_scheduler.sv
module tb_harq_combine_scheduler;

  localparam int NU  = 8;
  localparam int CBW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start;
  logic [NU-1:0]     en;
  logic [NU*CBW-1:0] cnts;
  logic              auto_comp, man_comp, auto_send, man_send;
  logic              comp, send;
  assign comp = auto_comp | man_comp;
  assign send = auto_send | man_send;

  logic           req;
  logic [3:0]     uidx;
  logic [CBW-1:0] cbidx;
  logic           busy, done, ovr;
  logic [1:0]     occ;
`ifdef HARQ_COMB_SCHED_WATCHDOG_EN
  logic           terr;
`endif

  harq_combine_scheduler #(
    .NUM_USERS(NU), .CB_W(CBW), .TIMEOUT_CYCLES(16)
  ) dut (
    .i_core_clk                (clk),
    .i_rx_rst                  (rst),
    .i_rdm_slot_start          (start),
    .i_user_enable             (en),
    .i_user_cb_num             (cnts),
    .o_Combine_process_request (req),
    .o_Combine_user_index      (uidx),
    .o_cb_index                (cbidx),
    .i_current_cb_combine_comp (comp),
    .i_SENDHARQ_Data_Comp      (send),
    .o_busy                    (busy),
    .o_slot_done               (done),
    .o_slot_overrun            (ovr),
    .o_buf_occupancy           (occ)
`ifdef HARQ_COMB_SCHED_WATCHDOG_EN
    ,.o_timeout_err            (terr)
`endif
  );

  typedef struct { int u; int cb; } req_t;
  req_t exp_q[$];

  int checks = 0, failures = 0;
  int m_occ = 0;
  bit chk_en = 1'b0;
  int done_cnt = 0, ovr_cnt = 0, req_cnt = 0;
  bit resp_en = 1'b0, send_en = 1'b1;
  int comp_cd = 0;
  bit pend_send = 1'b0;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Occupancy model: filled minus sent, clamped to the two physical buffers.
  function automatic int occ_next(input int o, input logic inc, input logic dec);
    int t;
    t = o + (inc ? 1 : 0) - (dec ? 1 : 0);
    if (t > 2) t = 2;
    if (t < 0) t = 0;
    return t;
  endfunction

  always @(posedge clk) m_occ <= rst ? 0 : occ_next(m_occ, comp, send);

  // Expected request order: users ascending, code blocks ascending.
  task automatic build_exp(input logic [NU-1:0] e, input logic [NU*CBW-1:0] c);
    for (int u = 0; u < NU; u++) begin
      if (e[u]) begin
        for (int k = 0; k < int'(c[u*CBW +: CBW]); k++) begin
          req_t r;
          r.u = u;
          r.cb = k;
          exp_q.push_back(r);
        end
      end
    end
  endtask

  // Compare process
  always @(negedge clk) begin
    if (chk_en) begin
      check("occupancy", int'(occ), m_occ);
      if (done) done_cnt++;
      if (ovr) ovr_cnt++;
      if (req) begin
        req_cnt++;
        check("req_busy", int'(busy), 1);
        check("req_while_full", int'(m_occ == 2), 0);
        check("req_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          req_t r;
          r = exp_q.pop_front();
          check("req_user", int'(uidx), r.u);
          check("req_cb", int'(cbidx), r.cb);
        end
      end
    end
  end

  // Combine-done 5 cycles after each request, send-done on the following cycle.
  initial begin
    auto_comp = 1'b0;
    auto_send = 1'b0;
    forever begin
      @(negedge clk);
      auto_comp = 1'b0;
      auto_send = 1'b0;
      if (rst) begin
        comp_cd = 0;
        pend_send = 1'b0;
      end else begin
        if (pend_send) begin
          auto_send = send_en;
          pend_send = 1'b0;
        end
        if (comp_cd > 0) begin
          comp_cd--;
          if (comp_cd == 0) begin
            auto_comp = 1'b1;
            pend_send = 1'b1;
          end
        end
        if (req && resp_en) comp_cd = 5;
      end
    end
  end

  task automatic start_slot(input logic [NU-1:0] e, input logic [NU*CBW-1:0] c);
    start = 1'b1;
    en = e;
    cnts = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int n;
    n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(done), 1);
  endtask

  task automatic wait_reqs(input int target, input int maxc, input string name);
    int n;
    n = 0;
    while (req_cnt < target && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(req_cnt >= target), 1);
  endtask

  task automatic clear_counts();
    done_cnt = 0;
    ovr_cnt = 0;
    req_cnt = 0;
  endtask

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; en = '0; cnts = '0;
    man_comp = 1'b0; man_send = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_req", int'(req), 0);
    check("rst_done", int'(done), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_occ", int'(occ), 0);
    check("rst_user", int'(uidx), 0);
    check("rst_cb", int'(cbidx), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);

    // T1: users 0 (2 cbs) and 2 (1 cb); user1 disabled, user3 enabled with 0 cbs
    clear_counts(); resp_en = 1'b1; send_en = 1'b1;
    build_exp(8'h0D, 64'h0000_0000_0001_0302);
    check("t1_model_len", exp_q.size(), 3);
    check("t1_model_cb1", exp_q[1].cb, 1);
    check("t1_model_u2", exp_q[2].u, 2);
    start_slot(8'h0D, 64'h0000_0000_0001_0302);
    check("t1_busy", int'(busy), 1);
    @(negedge clk);
    check("t1_no_early_req", int'(req), 0);
    @(negedge clk);
    check("t1_first_req_latency", int'(req), 1);
    wait_done(200, "t1_done_seen");
    repeat (3) @(negedge clk);
    check("t1_done_cnt", done_cnt, 1);
    check("t1_req_cnt", req_cnt, 3);
    check("t1_left", exp_q.size(), 0);
    check("t1_occ_end", int'(occ), 0);
    check("t1_idle", int'(busy), 0);

    // T2: nothing enabled; a start landing on the DONE cycle is refused
    clear_counts();
    start_slot(8'h00, 64'h0);
    check("t2_busy", int'(busy), 1);
    @(negedge clk);
    check("t2_done_latency", int'(done), 1);
    start = 1'b1; en = 8'h01; cnts = 64'h1;
    @(negedge clk);
    start = 1'b0;
    check("t2_ovr_on_done", int'(ovr), 1);
    check("t2_not_accepted", int'(busy), 0);
    repeat (10) @(negedge clk);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_ovr_cnt", ovr_cnt, 1);
    check("t2_req_cnt", req_cnt, 0);

    // T3: no sends -> third request held until one buffer is released
    clear_counts(); send_en = 1'b0;
    build_exp(8'h01, 64'h3);
    start_slot(8'h01, 64'h3);
    wait_reqs(2, 100, "t3_two_reqs");
    repeat (12) @(negedge clk);
    check("t3_held_req_cnt", req_cnt, 2);
    check("t3_held_occ", int'(occ), 2);
    check("t3_held_busy", int'(busy), 1);
    man_send = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) man_send = 1'b0;
    end while (!req && n < 10);
    check("t3_release_latency", n, 2);
    wait_done(100, "t3_done_seen");
    @(negedge clk);
    check("t3_occ_after_slot", int'(occ), 2);
    repeat (3) begin
      man_send = 1'b1;
      @(negedge clk);
      man_send = 1'b0;
      @(negedge clk);
    end
    check("t3_drained_sat0", int'(occ), 0);
    check("t3_req_cnt", req_cnt, 3);
    send_en = 1'b1;

    // T4: slot start while busy
    clear_counts();
    build_exp(8'h01, 64'h1);
    start_slot(8'h01, 64'h1);
    repeat (4) @(negedge clk);
    start = 1'b1; en = 8'hFF; cnts = '1;
    @(negedge clk);
    start = 1'b0;
    check("t4_ovr_pulse", int'(ovr), 1);
    @(negedge clk);
    check("t4_ovr_single", int'(ovr), 0);
    wait_done(100, "t4_done_seen");
    repeat (3) @(negedge clk);
    check("t4_done_cnt", done_cnt, 1);
    check("t4_ovr_cnt", ovr_cnt, 1);
    check("t4_req_cnt", req_cnt, 1);

    // T5: stray combine-done in IDLE, then reset while waiting for completion
    clear_counts(); resp_en = 1'b0;
    man_comp = 1'b1;
    @(negedge clk);
    man_comp = 1'b0;
    check("t5_stray_comp_occ", int'(occ), 1);
    build_exp(8'h04, 64'h0002_0000);
    start_slot(8'h04, 64'h0002_0000);
    wait_reqs(1, 50, "t5_req_seen");
    repeat (2) @(negedge clk);
    check("t5_pre_user", int'(uidx), 2);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_busy", int'(busy), 0);
    check("t5_rst_req", int'(req), 0);
    check("t5_rst_user", int'(uidx), 0);
    check("t5_rst_cb", int'(cbidx), 0);
    check("t5_rst_occ", int'(occ), 0);
    check("t5_rst_done", int'(done), 0);
    check("t5_rst_ovr", int'(ovr), 0);
    exp_q.delete();
    rst = 1'b0;
    @(negedge clk);
    check("t5_no_done", done_cnt, 0);
    clear_counts(); resp_en = 1'b1;
    build_exp(8'h03, 64'h0101);
    start_slot(8'h03, 64'h0101);
    wait_done(200, "t5_rerun_done");
    repeat (3) @(negedge clk);
    check("t5_rerun_reqs", req_cnt, 2);
    check("t5_rerun_left", exp_q.size(), 0);

    // T6: top user with the maximum code-block count
    clear_counts();
    build_exp(8'h80, 64'hFF00_0000_0000_0000);
    start_slot(8'h80, 64'hFF00_0000_0000_0000);
    wait_done(4000, "t6_done_seen");
    repeat (3) @(negedge clk);
    check("t6_req_cnt", req_cnt, 255);
    check("t6_left", exp_q.size(), 0);
    check("t6_done_cnt", done_cnt, 1);

`ifdef HARQ_COMB_SCHED_WATCHDOG_EN
    // Watchdog: completion never arrives
    clear_counts(); resp_en = 1'b0;
    build_exp(8'h01, 64'h1);
    start_slot(8'h01, 64'h1);
    n = 0;
    while (!req && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wd_req_seen", int'(req), 1);
    n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 16) check("wd_err_not_early", int'(terr), 0);
    end
    check("wd_done_delay", n, 17);
    check("wd_err_set", int'(terr), 1);
    repeat (3) @(negedge clk);
    check("wd_err_sticky", int'(terr), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL global_timeout: simulation did not finish, time %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "global timeout");
  end

endmodule
